// File: rtl/servisia_xmem_pkg.sv
// Shared definitions for the external asynchronous memory controller.
// Provides the FSM state type, the wait counter width, and the
// bank-select width helper used to size the chip address.
package servisia_xmem_pkg;

  localparam int WAIT_CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    HOLD   = 2'd3
  } state_t;

  // Number of upper address bits used to select a chip.
  // Never narrower than one bit, even for a single chip.
  function automatic int bank_sel_w(input int num_banks);
    int w;
    w = $clog2(num_banks);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/servisia_xmem_wait_cnt.sv
// Loadable down counter that times the ACCESS phase.
// Ports:
//   clk      clock
//   rst_n    asynchronous reset, active low
//   load     load load_val this cycle (SETUP -> ACCESS)
//   load_val number of extra ACCESS cycles
//   en       count down while in ACCESS
//   done     counter has reached zero (last ACCESS cycle)
module servisia_xmem_wait_cnt
  import servisia_xmem_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic [WAIT_CNT_W-1:0] load_val,
  input  logic                  en,
  output logic                  done
);

  logic [WAIT_CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (en && (cnt != '0)) begin
      cnt <= cnt - WAIT_CNT_W'(1);
    end
  end

  assign done = (cnt == '0);

endmodule

// File: rtl/servisia_xmem_ctrl.sv
// Controller for external asynchronous parallel memories (flash/SRAM)
// sharing one data bus. Decodes the chip from the upper address bits and
// drives registered chip-enable, output-enable and write-enable strobes
// through SETUP, ACCESS (WAIT_x+1 cycles) and HOLD phases.
//
// Optional feature: define SERVISIA_XMEM_WP_EN to write-protect bank 0
// (writes run full timing with we_n high, bus undriven, err_o=1).
//
// Ports:
//   clk_i, rst_ni       clock, asynchronous active-low reset
//   scan_en_i           blocks all writes and bus drive
//   req_i/gnt_o         request handshake; gnt_o high only when idle
//   we_i, addr_i,
//   wdata_i             transaction command
//   rvalid_o            one-cycle response pulse (reads and writes)
//   rdata_o             read data, holds until the next read completes
//   err_o               bank out of range or write-protect hit
//   mem_addr_o          chip address
//   mem_ce_no/oe_no/we_no  per-chip active-low strobes
//   mem_dq_o/dq_oe_o    write data and tristate drive enable
//   mem_dq_i            read data from the bus
module servisia_xmem_ctrl
  import servisia_xmem_pkg::*;
#(
  parameter  int DATA_W     = 8,
  parameter  int ADDR_W     = 20,
  parameter  int NUM_BANKS  = 2,
  parameter  int WAIT_RD    = 1,
  parameter  int WAIT_WR    = 2,
  localparam int BANK_SEL_W = bank_sel_w(NUM_BANKS),
  localparam int CHIP_AW    = ADDR_W - BANK_SEL_W
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 scan_en_i,
  input  logic                 req_i,
  input  logic                 we_i,
  input  logic [ADDR_W-1:0]    addr_i,
  input  logic [DATA_W-1:0]    wdata_i,
  output logic                 gnt_o,
  output logic                 rvalid_o,
  output logic [DATA_W-1:0]    rdata_o,
  output logic                 err_o,
  output logic [CHIP_AW-1:0]   mem_addr_o,
  output logic [NUM_BANKS-1:0] mem_ce_no,
  output logic [NUM_BANKS-1:0] mem_oe_no,
  output logic [NUM_BANKS-1:0] mem_we_no,
  output logic [DATA_W-1:0]    mem_dq_o,
  output logic                 mem_dq_oe_o,
  input  logic [DATA_W-1:0]    mem_dq_i
);

  state_t state, state_nx;

  logic accept;
  logic wait_done;

  // Decode of the incoming request
  logic [BANK_SEL_W-1:0] bank_in;
  logic [NUM_BANKS-1:0]  hot_in;
  logic                  wp_in;
  logic                  wr_ok_in;
  logic                  err_in;

  // Latched transaction
  logic [NUM_BANKS-1:0]  hot_q;
  logic                  we_q;
  logic                  wr_ok_q;
  logic                  err_q;

  // Transaction view used to compute the next strobe values: on the
  // accepting edge the latches are not loaded yet, so take the inputs.
  logic [NUM_BANKS-1:0]  t_hot;
  logic                  t_we;
  logic                  t_wr_ok;

  // Flop inputs for the bus-side outputs
  logic [NUM_BANKS-1:0]  ce_n_d;
  logic [NUM_BANKS-1:0]  oe_n_d;
  logic [NUM_BANKS-1:0]  we_n_d;
  logic                  dq_oe_d;

  assign accept  = req_i && (state == IDLE);
  assign bank_in = addr_i[ADDR_W-1 -: BANK_SEL_W];

  // One-hot bank decode; an out-of-range bank yields all zeros, so no
  // strobe is ever asserted for it.
  always_comb begin
    hot_in = '0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      hot_in[b] = (bank_in == BANK_SEL_W'(b));
    end
  end

`ifdef SERVISIA_XMEM_WP_EN
  assign wp_in = we_i & hot_in[0];
`else
  assign wp_in = 1'b0;
`endif

  assign wr_ok_in = we_i & (|hot_in) & ~wp_in;
  assign err_in   = ~(|hot_in) | wp_in;

  assign t_hot   = accept ? hot_in   : hot_q;
  assign t_we    = accept ? we_i     : we_q;
  assign t_wr_ok = accept ? wr_ok_in : wr_ok_q;

  servisia_xmem_wait_cnt u_wait_cnt (
    .clk      (clk_i),
    .rst_n    (rst_ni),
    .load     (state == SETUP),
    .load_val (we_q ? WAIT_CNT_W'(WAIT_WR) : WAIT_CNT_W'(WAIT_RD)),
    .en       (state == ACCESS),
    .done     (wait_done)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next state plus the strobe values for the phase being entered, so the
  // registered strobes line up exactly with the FSM phase.
  always_comb begin
    state_nx = state;
    ce_n_d   = '1;
    oe_n_d   = '1;
    we_n_d   = '1;
    dq_oe_d  = 1'b0;

    case (state)
      IDLE:    if (accept) state_nx = SETUP;
      SETUP:   state_nx = ACCESS;
      ACCESS:  if (wait_done) state_nx = HOLD;
      HOLD:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase

    if (state_nx != IDLE) begin
      ce_n_d  = ~t_hot;
      dq_oe_d = t_wr_ok & ~scan_en_i;
    end

    if (state_nx == ACCESS) begin
      if (t_we) begin
        if (t_wr_ok && !scan_en_i) we_n_d = ~t_hot;
      end else begin
        oe_n_d = ~t_hot;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      hot_q   <= '0;
      we_q    <= 1'b0;
      wr_ok_q <= 1'b0;
      err_q   <= 1'b0;
    end else if (accept) begin
      hot_q   <= hot_in;
      we_q    <= we_i;
      wr_ok_q <= wr_ok_in;
      err_q   <= err_in;
    end
  end

  // Bus-side outputs, all registered. Address and write data are loaded
  // on accept and held through HOLD and beyond.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mem_ce_no   <= '1;
      mem_oe_no   <= '1;
      mem_we_no   <= '1;
      mem_dq_oe_o <= 1'b0;
      mem_addr_o  <= '0;
      mem_dq_o    <= '0;
    end else begin
      mem_ce_no   <= ce_n_d;
      mem_oe_no   <= oe_n_d;
      mem_we_no   <= we_n_d;
      mem_dq_oe_o <= dq_oe_d;
      if (accept) begin
        mem_addr_o <= addr_i[CHIP_AW-1:0];
        if (we_i) mem_dq_o <= wdata_i;
      end
    end
  end

  // Read data sampled on the edge that ends ACCESS.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rdata_o <= '0;
    end else if ((state == ACCESS) && wait_done && !we_q) begin
      rdata_o <= (|hot_q) ? mem_dq_i : '0;
    end
  end

  assign gnt_o    = (state == IDLE);
  assign rvalid_o = (state == HOLD);
  assign err_o    = (state == HOLD) && err_q;

endmodule
